// File: rtl/ram_req_ctrl_if.sv
// Request/response bundle between a bus master or sequencer and ram_req_ctrl.
// Request channel: reqValid/reqReady handshake carrying reqWrite, reqAddr, reqData.
// Response channel: respValid/respReady handshake carrying respData, respError; busy flags the clear sweep.
interface ram_req_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqData;
  logic                  respValid;
  logic                  respReady;
  logic [DATA_WIDTH-1:0] respData;
  logic                  respError;
  logic                  busy;

  modport master (
    output reqValid, reqWrite, reqAddr, reqData, respReady,
    input  reqReady, respValid, respData, respError, busy
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, respReady,
    output reqReady, respValid, respData, respError, busy
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Single-port synchronous RAM behind a valid/ready request channel, with a one-entry response register.
// Latency: response valid one cycle after the accept edge; optional zero-fill sweep of DEPTH cycles after reset.
// Backpressure: a held response stalls requests (reqReady = !respValid || respReady); requests are ignored while busy.
// Ports: clk (rising-edge clock), resetN (async active-low reset), bus (ram_req_ctrl_if.slave: request,
// response and busy signals).
module ram_req_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int DEPTH          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            resetN,
  ram_req_ctrl_if.slave   bus
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]         LAST_IDX = CW'(DEPTH - 1);
  // One extra bit so DEPTH = 2^ADDR_WIDTH is representable and the compare never wraps.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : ACTIVE;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [CW-1:0]         idx;
  logic                  accept;
  logic                  busy_int;
  logic                  req_ready;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_error;

  // Address decode: full-width compare against DEPTH, index only used when in range.
  assign in_range = ({1'b0, bus.reqAddr} < DEPTH_W);
  assign idx      = bus.reqAddr[CW-1:0];
  assign accept   = bus.reqValid && req_ready;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: the sweep ends on the edge that clears the last word; ACTIVE is terminal.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Output logic. reqReady is gated by resetN so it reads 0 while reset is held,
  // even when the design resets straight into ACTIVE.
  always_comb begin
    busy_int  = 1'b0;
    req_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy_int  = 1'b1;
        req_ready = 1'b0;
      end
      ACTIVE: begin
        busy_int  = 1'b0;
        req_ready = resetN && (!resp_valid || bus.respReady);
      end
      default: begin
        busy_int  = 1'b0;
        req_ready = 1'b0;
      end
    endcase
  end

  // Clear sweep address counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Storage array: no reset. Writes are suppressed while resetN is low so that
  // holding reset never disturbs contents (the FSM sits in CLEAR at address 0 then).
  always_ff @(posedge clk) begin
    if (resetN) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && bus.reqWrite && in_range) begin
        mem[idx] <= bus.reqData;
      end
    end
  end

  // Response register. Loads on accept (also when the previous response is
  // consumed at the same edge, so there is no bubble); otherwise a consume only
  // drops valid and leaves data/error untouched. Reads see pre-write contents,
  // which is irrelevant here since a request is either a read or a write.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      if (in_range) begin
        resp_data  <= bus.reqWrite ? bus.reqData : mem[idx];
        resp_error <= 1'b0;
      end else begin
        resp_data  <= '0;
        resp_error <= 1'b1;
      end
    end else if (resp_valid && bus.respReady) begin
      resp_valid <= 1'b0;
    end
  end

  assign bus.reqReady  = req_ready;
  assign bus.busy      = busy_int;
  assign bus.respValid = resp_valid;
  assign bus.respData  = resp_data;
  assign bus.respError = resp_error;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Testbench for ram_req_ctrl: two instances (32x8 with clear sweep, 20x16 without).
// Instance A is checked cycle by cycle against a behavioural model; instance B with directed expectations.
// All outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_ram_req_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks;
  int errors;

  ram_req_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(5)) ia ();
  ram_req_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) ib ();

  ram_req_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk    (clk),
    .resetN (rst_a),
    .bus    (ia)
  );

  ram_req_ctrl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(20), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk    (clk),
    .resetN (rst_b),
    .bus    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for instance A: memory image plus the single pending response.
  logic [7:0] m_mem [32];
  bit         m_v;
  logic [7:0] m_d;
  bit         m_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_v = 1'b0;
    m_d = 8'h00;
    m_e = 1'b0;
  endtask

  // One cycle on instance A; called at a falling edge, returns at the next falling edge.
  task automatic a_step(input bit v, input bit w, input logic [4:0] a, input logic [7:0] d, input bit r);
    bit acc;
    ia.reqValid  = v;
    ia.reqWrite  = w;
    ia.reqAddr   = a;
    ia.reqData   = d;
    ia.respReady = r;
    #1;
    chk("a_reqReady", {31'b0, ia.reqReady}, {31'b0, (!m_v || r)});
    acc = v && (!m_v || r);
    @(posedge clk);
    if (acc) begin
      m_v = 1'b1;
      m_e = 1'b0;
      if (w) begin
        m_mem[a] = d;
        m_d      = d;
      end else begin
        m_d = m_mem[a];
      end
    end else if (m_v && r) begin
      m_v = 1'b0;
    end
    @(negedge clk);
    chk("a_respValid", {31'b0, ia.respValid}, {31'b0, m_v});
    chk("a_respData",  {24'b0, ia.respData},  {24'b0, m_d});
    chk("a_respError", {31'b0, ia.respError}, {31'b0, m_e});
    chk("a_busy",      {31'b0, ia.busy},      32'd0);
  endtask

  // One accepted request on instance B with respReady held high; directed expectation.
  task automatic b_step(input bit w, input logic [4:0] a, input logic [15:0] d,
                        input logic [15:0] exp_d, input bit exp_e);
    ib.reqValid  = 1'b1;
    ib.reqWrite  = w;
    ib.reqAddr   = a;
    ib.reqData   = d;
    ib.respReady = 1'b1;
    #1;
    chk("b_reqReady", {31'b0, ib.reqReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b_respValid", {31'b0, ib.respValid}, 32'd1);
    chk("b_respData",  {16'b0, ib.respData},  {16'b0, exp_d});
    chk("b_respError", {31'b0, ib.respError}, {31'b0, exp_e});
  endtask

  // Count DEPTH edges after release of A: busy until the 32nd edge, no response appears.
  task automatic a_sweep(input string tag);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy"},      {31'b0, ia.busy},      (i < 32) ? 32'd1 : 32'd0);
      chk({tag, "_reqReady"},  {31'b0, ia.reqReady},  (i < 32) ? 32'd0 : 32'd1);
      chk({tag, "_respValid"}, {31'b0, ia.respValid}, 32'd0);
    end
  endtask

  initial begin
    bit         rv;
    bit         rw;
    bit         rr;
    logic [4:0] ra;
    logic [7:0] rd;

    checks = 0;
    errors = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.reqValid = 1'b0; ia.reqWrite = 1'b0; ia.reqAddr = '0; ia.reqData = '0; ia.respReady = 1'b0;
    ib.reqValid = 1'b0; ib.reqWrite = 1'b0; ib.reqAddr = '0; ib.reqData = '0; ib.respReady = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_respValid", {31'b0, ia.respValid}, 32'd0);
    chk("rst_a_respData",  {24'b0, ia.respData},  32'd0);
    chk("rst_a_respError", {31'b0, ia.respError}, 32'd0);
    chk("rst_a_busy",      {31'b0, ia.busy},      32'd1);
    chk("rst_a_reqReady",  {31'b0, ia.reqReady},  32'd0);
    chk("rst_b_respValid", {31'b0, ib.respValid}, 32'd0);
    chk("rst_b_busy",      {31'b0, ib.busy},      32'd0);
    chk("rst_b_reqReady",  {31'b0, ib.reqReady},  32'd0);

    // Release A: sweep lasts exactly 32 edges.
    @(negedge clk);
    rst_a = 1'b1;
    a_sweep("sweep1");
    model_clear();

    // Every word reads back zero after the sweep.
    for (int a = 0; a < 32; a++) a_step(1'b1, 1'b0, 5'(a), 8'h00, 1'b1);
    a_step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);

    // Write then read the same address back to back.
    a_step(1'b1, 1'b1, 5'd0, 8'h5A, 1'b1);
    a_step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1);
    a_step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);

    // Held response under backpressure, then consume.
    a_step(1'b1, 1'b1, 5'd3, 8'hC3, 1'b1);
    a_step(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    repeat (3) a_step(1'b1, 1'b0, 5'd9, 8'h00, 1'b0);
    chk("hold_data", {24'b0, ia.respData}, 32'h0000_00C3);
    a_step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);

    // Randomised traffic.
    repeat (400) begin
      rv = 1'($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      rd = 8'($urandom);
      rr = 1'($urandom_range(0, 3) != 0);
      a_step(rv, rw, ra, rd, rr);
    end

    // Reset with a response outstanding, then reset again mid-sweep at counter 10.
    a_step(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_respValid", {31'b0, ia.respValid}, 32'd0);
    chk("mid_rst_respData",  {24'b0, ia.respData},  32'd0);
    chk("mid_rst_busy",      {31'b0, ia.busy},      32'd1);
    chk("mid_rst_reqReady",  {31'b0, ia.reqReady},  32'd0);
    ia.reqValid = 1'b1; ia.reqWrite = 1'b1; ia.reqAddr = 5'd5; ia.reqData = 8'hFF; ia.respReady = 1'b1;
    @(negedge clk);
    rst_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("sweep_busy_at10", {31'b0, ia.busy}, 32'd1);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    a_sweep("sweep2");
    model_clear();
    a_step(1'b1, 1'b0, 5'd0,  8'h00, 1'b1);
    a_step(1'b1, 1'b0, 5'd3,  8'h00, 1'b1);
    a_step(1'b1, 1'b0, 5'd5,  8'h00, 1'b1);
    a_step(1'b1, 1'b0, 5'd31, 8'h00, 1'b1);
    a_step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1);

    // Instance B: no sweep, DEPTH=20 with 5-bit addresses.
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("b_first_reqReady", {31'b0, ib.reqReady}, 32'd1);
    chk("b_first_busy",     {31'b0, ib.busy},     32'd0);
    b_step(1'b1, 5'd7,  16'hBEEF, 16'hBEEF, 1'b0);
    b_step(1'b0, 5'd7,  16'h0000, 16'hBEEF, 1'b0);
    b_step(1'b1, 5'd5,  16'h1234, 16'h1234, 1'b0);
    b_step(1'b1, 5'd25, 16'h00FF, 16'h0000, 1'b1);
    b_step(1'b0, 5'd5,  16'h0000, 16'h1234, 1'b0);
    b_step(1'b1, 5'd19, 16'hAAAA, 16'hAAAA, 1'b0);
    b_step(1'b0, 5'd20, 16'h0000, 16'h0000, 1'b1);
    b_step(1'b0, 5'd19, 16'h0000, 16'hAAAA, 1'b0);
    ib.reqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b_consume_valid", {31'b0, ib.respValid}, 32'd0);
    chk("b_consume_data",  {16'b0, ib.respData},  32'h0000_AAAA);
    chk("b_consume_error", {31'b0, ib.respError}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Parametrised single-port synchronous RAM with a valid/ready request channel and a back-pressurable response channel. It is the successor to the control RAM, which had a bare addr/dataIn/writeEnable/dataOut interface. Additions: configurable width and depth, an optional hardware clear sweep after reset, out-of-range address detection, and a one-response buffer that holds read data until the consumer takes it. It sits between a bus master or sequencer and its local scratch storage.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each word
- ADDR_WIDTH, 5, width of reqAddr
- DEPTH, 32, number of implemented words; legal range 1..2^ADDR_WIDTH
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset, 0 = skip the sweep

Ports:
- clk  input  1  rising-edge clock, the only clock
- resetN  input  1  reset; asynchronous assert, active-low
- reqValid  input  1  request present
- reqReady  output  1  request accepted when reqValid && reqReady at a rising edge
- reqWrite  input  1  1 = write, 0 = read
- reqAddr  input  ADDR_WIDTH  word address
- reqData  input  DATA_WIDTH  write data, ignored for reads
- respValid  output  1  response present
- respReady  input  1  response consumed when respValid && respReady at a rising edge
- respData  output  DATA_WIDTH  read data, or echoed write data
- respError  output  1  request address >= DEPTH
- busy  output  1  clear sweep in progress

## Operation
- The FSM has two states, CLEAR and ACTIVE.
- Reset (resetN low) forces, asynchronously:
  - state = CLEAR if CLEAR_ON_RESET = 1, else ACTIVE;
  - clear counter = 0;
  - respValid = 0, respData = 0, respError = 0;
  - busy = CLEAR_ON_RESET, reqReady = 0.
- Memory contents are not affected by reset itself.
- CLEAR state:
  - each rising edge writes 0 to mem[counter], then the counter increments;
  - the edge that writes DEPTH-1 moves the FSM to ACTIVE;
  - reqReady = 0 and busy = 1 throughout; requests are ignored, not queued.
- ACTIVE state:
  - busy = 0 and reqReady = !respValid || respReady (combinational).
  - An accepted request produces exactly one response, in order.
  - Read, addr < DEPTH: respData = mem[addr], respError = 0.
  - Write, addr < DEPTH: mem[addr] = reqData at the accept edge; respData = reqData, respError = 0.
  - Any request with addr >= DEPTH: no memory access, respData = 0, respError = 1.
- The response register loads at the accept edge. It holds respData and respError stable while respValid && !respReady.
- A response is consumed with no new accept: respValid falls to 0 at that edge; respData and respError keep their last values.
- ACTIVE never returns to CLEAR except through reset.
- With CLEAR_ON_RESET = 0, reads of never-written words return unspecified data (X in simulation).

## Timing
- Request-to-response latency is 1 cycle: respValid is high after the accept edge.
- Throughput is one request per cycle while respReady is held at 1.
- Simultaneous consume and accept at one edge: respValid stays 1 and the register carries the new response, with no bubble.
- Back-to-back write then read of the same address: the read returns the new data, because the write commits at its own accept edge.
- Clear duration:
  - reqReady first rises after exactly DEPTH rising edges with resetN high;
  - the first accept can occur at edge DEPTH+1;
  - with CLEAR_ON_RESET = 0, the first accept can occur at the first edge after release.
- Reset asserted mid-sweep or mid-transaction:
  - the outstanding response is dropped;
  - with CLEAR_ON_RESET = 1 the sweep restarts from address 0.
- Out-of-range checking compares the full ADDR_WIDTH against DEPTH. There is no wrap or truncation.

## Test plan
- Reset release, CLEAR_ON_RESET=1, DEPTH=32: busy=1 and reqReady=0 for 32 edges, then busy=0 and reqReady=1. Reading every address 0..31 returns 0x00 with respError=0.
- Write 0x5A to addr 0, then read addr 0 on the next cycle with respReady=1: responses 0x5A (echo) then 0x5A. respValid stays high for 2 consecutive cycles.
- Read addr 3 (holding 0xC3) with respReady=0 for 4 cycles: respValid=1, respData=0xC3 stable, reqReady=0. respReady=1 then consumes it, and reqReady=1 in the same cycle.
- DEPTH=20, ADDR_WIDTH=5, write 0xFF to addr 25: respError=1 and respData=0x00. A read of addr 25-20=5 shows that word unchanged.
- Assert resetN low mid-sweep at counter 10, release, and wait: the sweep restarts (busy for 32 edges from release) and respValid stays 0 throughout.
- CLEAR_ON_RESET=0, DATA_WIDTH=16: reqReady=1 on the first cycle after release. Write 0xBEEF to addr 7, read addr 7 → 0xBEEF.
